// File: rtl/dmem_bytes.sv
// dmem_bytes: byte-addressable data memory with RV32I sub-word loads/stores,
// access fault detection and a sequential clear sweep with busy/done handshake.
module dmem_bytes #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       mem_in,
   input  logic [2:0]        funct3,
   input  logic              store,
   input  logic              load,
   input  logic              clr,
   output logic [31:0]       dout,
   output logic              fault,
   output logic              busy,
   output logic              clr_done
);
   localparam int CNT_W = ADDR_W - 2;
   localparam int DEPTH = 2 ** CNT_W;
   localparam logic [CNT_W-1:0] LAST = {CNT_W{1'b1}};

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             clr_done_q, clr_done_d;

   logic [31:0]      mem [DEPTH];
   logic [CNT_W-1:0] word;
   logic [1:0]       lane;
   logic             legal, size_h, size_w, uns, misal, we;
   logic [3:0]       be;
   logic [31:0]      wdata, rdata, ext;
   logic [7:0]       rbyte;
   logic [15:0]      rhalf;

   assign word     = addr[ADDR_W-1:2];
   assign lane     = addr[1:0];
   assign busy     = busy_q;
   assign clr_done = clr_done_q;

   always_comb begin
      legal  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      size_h = funct3[1:0] == 2'b01;
      size_w = funct3 == 3'b010;
      uns    = funct3[2];
      misal  = (size_h && lane[0]) || (size_w && lane != 2'b00);
      fault  = (store || load) && (!legal || misal || (store && uns));
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be    = size_w ? 4'hF : size_h ? (lane[1] ? 4'hC : 4'h3) : 4'b0001 << lane;
      wdata = size_w ? mem_in : size_h ? {2{mem_in[15:0]}} : {4{mem_in[7:0]}};
      we    = store && !fault && !busy_q;
   end

   always_comb begin
      rdata = mem[word];
      rbyte = rdata[{lane, 3'b000} +: 8];
      rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
      ext   = size_w ? rdata
            : size_h ? (uns ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf})
            : (uns ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte});
      dout  = (load && !fault && !busy_q) ? ext : 32'b0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (clr) begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
      end else if (cnt_q == LAST) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      busy_d     = state_d == CLEAR;
      clr_done_d = state_d == CLEAR && cnt_d == LAST;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         clr_done_q <= clr_done_d;
      end
   end

   // Storage ignores reset: a sweep word written on the reset edge stays cleared.
   always_ff @(posedge clk) begin
      if (busy_q)
         mem[cnt_q] <= 32'b0;
      else if (we)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[word][8*i +: 8] <= wdata[8*i +: 8];
   end
endmodule
